// File: rtl/multiplicador_referencia.sv
// multiplicador_referencia: lock-in mixer, ADC sample times reference table.
// Define MULTIPLICADOR_QUADRATURE_EN to build the 90-degree (Q) channel.
module multiplicador_referencia #(
  parameter int DATA_W  = 14,
  parameter int REF_W   = 16,
  parameter int buf_tam = 4096
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [15:0]                ptos_x_ciclo,
  input  logic                       ref_wr_en,
  input  logic [$clog2(buf_tam)-1:0] ref_wr_addr,
  input  logic [REF_W-1:0]           ref_wr_data,
  input  logic                       data_valid,
  input  logic [DATA_W-1:0]          data,
  output logic [63:0]                data_out_i,
  output logic [63:0]                data_out_q,
  output logic                       data_out_valid,
  output logic                       ciclo_completo,
  output logic                       error_config
);

  localparam int AW = $clog2(buf_tam);
  localparam int PW = DATA_W + REF_W;
  localparam logic [16:0] TAM = 17'(buf_tam);

  logic [15:0]           M_reg;
  logic [15:0]           indice;
  logic                  acepta;
  logic                  ultimo;
  logic                  m_fuera;
  logic                  cfg_mal;

  logic                  s1_valid;
  logic                  s1_last;
  logic [DATA_W-1:0]     s1_data;
  logic [AW-1:0]         s1_idx;

  logic                  s2_valid;
  logic                  s2_last;
  logic [DATA_W-1:0]     s2_data;
  logic [REF_W-1:0]      s2_ref_i;

  logic [REF_W-1:0]      mem [buf_tam];
  logic signed [PW-1:0]  prod_i;

  assign acepta  = enable & data_valid & ~error_config;
  assign ultimo  = (indice == M_reg - 16'd1);
  assign m_fuera = (M_reg == 16'd0) | ({1'b0, M_reg} > TAM);

`ifdef MULTIPLICADOR_QUADRATURE_EN
  assign cfg_mal = m_fuera | (M_reg[1:0] != 2'b00);
`else
  assign cfg_mal = m_fuera;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      M_reg        <= '0;
      error_config <= 1'b1;
      indice       <= '0;
    end else begin
      if (!enable)
        M_reg <= ptos_x_ciclo;
      error_config <= cfg_mal;
      if (!enable)
        indice <= '0;
      else if (acepta)
        indice <= ultimo ? '0 : indice + 16'd1;
    end
  end

  // Valid bits reset; data registers only load on a valid sample.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= acepta;
      s1_last  <= acepta & ultimo;
      if (acepta) begin
        s1_data <= data;
        s1_idx  <= AW'(indice);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_valid & s1_last;
      if (s1_valid)
        s2_data <= s1_data;
    end
  end

  // Table RAM: read-during-write returns the old word.
  always_ff @(posedge clock) begin
    if (ref_wr_en)
      mem[ref_wr_addr] <= ref_wr_data;
    if (s1_valid)
      s2_ref_i <= mem[s1_idx];
  end

  assign prod_i = PW'($signed(s2_data)) * PW'($signed(s2_ref_i));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_out_i     <= '0;
      data_out_valid <= 1'b0;
      ciclo_completo <= 1'b0;
    end else begin
      data_out_valid <= s2_valid;
      ciclo_completo <= s2_valid & s2_last;
      if (s2_valid)
        data_out_i <= 64'(prod_i);
    end
  end

`ifdef MULTIPLICADOR_QUADRATURE_EN
  logic [15:0]          cuarto;
  logic [16:0]          suma_q;
  logic [16:0]          m_ext;
  logic [AW-1:0]        s1_idxq;
  logic [REF_W-1:0]     s2_ref_q;
  logic signed [PW-1:0] prod_q;

  assign suma_q = {1'b0, indice} + {1'b0, cuarto};
  assign m_ext  = {1'b0, M_reg};
  assign prod_q = PW'($signed(s2_data)) * PW'($signed(s2_ref_q));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cuarto     <= '0;
      s1_idxq    <= '0;
      data_out_q <= '0;
    end else begin
      if (!enable)
        cuarto <= ptos_x_ciclo >> 2;
      if (acepta)
        s1_idxq <= AW'(suma_q >= m_ext ? suma_q - m_ext : suma_q);
      if (s2_valid)
        data_out_q <= 64'(prod_q);
    end
  end

  always_ff @(posedge clock) begin
    if (s1_valid)
      s2_ref_q <= mem[s1_idxq];
  end
`else
  assign data_out_q = '0;
`endif

endmodule

// File: tb/tb_multiplicador_referencia.sv
// tb_multiplicador_referencia: randomized self-checking bench against a
// cycle-level reference model of the lock-in mixer.
module tb_multiplicador_referencia;

`ifdef MULTIPLICADOR_QUADRATURE_EN
  localparam bit QUAD = 1'b1;
`else
  localparam bit QUAD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] ptos_x_ciclo;
  logic        ref_wr_en;
  logic [11:0] ref_wr_addr;
  logic [15:0] ref_wr_data;
  logic        data_valid;
  logic [13:0] data;
  logic [63:0] data_out_i;
  logic [63:0] data_out_q;
  logic        data_out_valid;
  logic        ciclo_completo;
  logic        error_config;

  multiplicador_referencia dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .ptos_x_ciclo   (ptos_x_ciclo),
    .ref_wr_en      (ref_wr_en),
    .ref_wr_addr    (ref_wr_addr),
    .ref_wr_data    (ref_wr_data),
    .data_valid     (data_valid),
    .data           (data),
    .data_out_i     (data_out_i),
    .data_out_q     (data_out_q),
    .data_out_valid (data_out_valid),
    .ciclo_completo (ciclo_completo),
    .error_config   (error_config)
  );

  always #5 clock = ~clock;

  int asserts = 0;
  int fails = 0;

  typedef struct {
    int     due;
    longint i;
    longint q;
    bit     last;
  } exp_t;

  int          tbl [4096];
  int          m_cfg = 0;
  int          idx = 0;
  int          edge_n = 0;
  bit          err_m = 1'b1;
  exp_t        pend [$];
  logic        ev, el;
  logic [63:0] ei, eq;
  logic [63:0] last_i = '0;
  logic [63:0] last_q = '0;

  // Advance one clock edge, updating the model from the inputs now applied.
  task automatic clk_step();
    bit   acc;
    bit   ne;
    exp_t e;
    if (ref_wr_en)
      tbl[ref_wr_addr] = int'($signed(ref_wr_data));
    acc = enable && data_valid && !err_m;
    if (!reset_n) begin
      m_cfg = 0;
      err_m = 1'b1;
      idx = 0;
      pend.delete();
      last_i = '0;
      last_q = '0;
    end else begin
      if (acc) begin
        e.due = edge_n + 3;
        e.i = longint'($signed(data)) * longint'(tbl[idx]);
        e.q = QUAD ? longint'($signed(data)) *
              longint'(tbl[(idx + m_cfg / 4) % m_cfg]) : 64'sd0;
        e.last = (idx == m_cfg - 1);
        pend.push_back(e);
        idx = (idx + 1) % m_cfg;
      end
      if (!enable)
        idx = 0;
      ne = (m_cfg == 0) || (m_cfg > 4096) || (QUAD && (m_cfg % 4 != 0));
      if (!enable)
        m_cfg = int'(ptos_x_ciclo);
      err_m = ne;
    end
    @(posedge clock);
    #1;
    edge_n++;
    ev = 1'b0;
    el = 1'b0;
    if (pend.size() > 0 && pend[0].due == edge_n) begin
      e = pend.pop_front();
      ev = 1'b1;
      el = e.last;
      last_i = e.i;
      last_q = e.q;
    end
    ei = last_i;
    eq = last_q;
  endtask

  task automatic idle_inputs();
    enable = 1'b0;
    data_valid = 1'b0;
    ref_wr_en = 1'b0;
    data = '0;
  endtask

  task automatic write_tbl(input int a, input int v);
    ref_wr_en = 1'b1;
    ref_wr_addr = 12'(a);
    ref_wr_data = 16'(v);
    clk_step();
    ref_wr_en = 1'b0;
  endtask

  task automatic configure(input int m);
    idle_inputs();
    ptos_x_ciclo = 16'(m);
    clk_step();
    clk_step();
  endtask

  task automatic test_reset();
    idle_inputs();
    ptos_x_ciclo = 16'd8;
    ref_wr_addr = '0;
    ref_wr_data = '0;
    reset_n = 1'b0;
    clk_step();
    clk_step();
    asserts++;
    if (data_out_i !== 64'd0 || data_out_q !== 64'd0 ||
        data_out_valid !== 1'b0 || ciclo_completo !== 1'b0 ||
        error_config !== 1'b1) begin
      fails++;
      $display("FAIL reset: i=%0h q=%0h v=%b c=%b err=%b, required 0 0 0 0 1",
               data_out_i, data_out_q, data_out_valid, ciclo_completo,
               error_config);
    end
    reset_n = 1'b1;
    clk_step();
  endtask

  task automatic test_basic();
    int n_out = 0;
    int n_last = 0;
    int first_cyc = -1;
    for (int k = 0; k < 8; k++)
      write_tbl(k, k + 1);
    configure(8);
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      data_valid = (k < 16);
      data = 14'd100;
      clk_step();
      asserts++;
      if (data_out_valid !== ev || ciclo_completo !== el ||
          data_out_i !== ei || data_out_q !== eq ||
          error_config !== err_m) begin
        fails++;
        $display("FAIL basic k=%0d: v=%b c=%b i=%0d q=%0d, required %b %b %0d %0d",
                 k, data_out_valid, ciclo_completo, $signed(data_out_i),
                 $signed(data_out_q), ev, el, $signed(ei), $signed(eq));
      end
      if (data_out_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = k + 1;
        n_out++;
      end
      if (ciclo_completo === 1'b1) n_last++;
    end
    asserts++;
    if (n_out != 16 || n_last != 2 || first_cyc != 3) begin
      fails++;
      $display("FAIL basic_count: outputs=%0d pulses=%0d first=%0d, required 16 2 3",
               n_out, n_last, first_cyc);
    end
  endtask

  task automatic test_sign(input int ref_v, input longint want);
    logic [63:0] got = '0;
    idle_inputs();
    write_tbl(0, ref_v);
    configure(1);
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      data_valid = (k == 0);
      data = 14'h2000;
      clk_step();
      asserts++;
      if (data_out_valid !== ev || ciclo_completo !== el ||
          data_out_i !== ei || data_out_q !== eq) begin
        fails++;
        $display("FAIL sign k=%0d: v=%b c=%b i=%0h, required %b %b %0h",
                 k, data_out_valid, ciclo_completo, data_out_i, ev, el, ei);
      end
      if (data_out_valid === 1'b1) got = data_out_i;
    end
    asserts++;
    if (got !== 64'(want)) begin
      fails++;
      $display("FAIL sign_value: got %0h, required %0h", got, 64'(want));
    end
  endtask

  task automatic test_gapped();
    int n_out = 0;
    for (int k = 0; k < 4; k++)
      write_tbl(k, int'($urandom_range(0, 65535)) - 32768);
    configure(4);
    enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      data_valid = (k < 12) && (k % 2 == 0);
      data = 14'($urandom);
      clk_step();
      asserts++;
      if (data_out_valid !== ev || ciclo_completo !== el ||
          data_out_i !== ei || data_out_q !== eq) begin
        fails++;
        $display("FAIL gapped k=%0d: v=%b c=%b i=%0d q=%0d, required %b %b %0d %0d",
                 k, data_out_valid, ciclo_completo, $signed(data_out_i),
                 $signed(data_out_q), ev, el, $signed(ei), $signed(eq));
      end
      if (data_out_valid === 1'b1) n_out++;
    end
    asserts++;
    if (n_out != 6) begin
      fails++;
      $display("FAIL gapped_count: outputs=%0d, required 6", n_out);
    end
  endtask

  task automatic test_illegal();
    configure(0);
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      data_valid = 1'b1;
      data = 14'($urandom);
      clk_step();
      asserts++;
      if (data_out_valid !== 1'b0 || error_config !== 1'b1) begin
        fails++;
        $display("FAIL illegal_m0 k=%0d: v=%b err=%b, required 0 1",
                 k, data_out_valid, error_config);
      end
    end
    configure(4097);
    asserts++;
    if (error_config !== 1'b1) begin
      fails++;
      $display("FAIL illegal_m4097: err=%b, required 1", error_config);
    end
    configure(6);
    asserts++;
    if (error_config !== QUAD) begin
      fails++;
      $display("FAIL m6: err=%b, required %b", error_config, QUAD);
    end
  endtask

  task automatic test_reset_mid();
    configure(8);
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      data_valid = 1'b1;
      data = 14'($urandom);
      reset_n = (k != 2);
      clk_step();
      asserts++;
      if (data_out_valid !== 1'b0 || data_out_i !== ei ||
          data_out_q !== eq || ev !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid k=%0d: v=%b i=%0h q=%0h, required 0 %0h %0h",
                 k, data_out_valid, data_out_i, data_out_q, ei, eq);
      end
    end
    reset_n = 1'b1;
    asserts++;
    if (data_out_i !== 64'd0 || data_out_q !== 64'd0) begin
      fails++;
      $display("FAIL reset_mid_zero: i=%0h q=%0h, required 0 0",
               data_out_i, data_out_q);
    end
  endtask

  task automatic test_live_write();
    logic [63:0] outs [16];
    int n = 0;
    for (int k = 0; k < 8; k++)
      write_tbl(k, k + 1);
    configure(8);
    enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      data_valid = (k < 12);
      data = 14'd1;
      ref_wr_en = (k == 3);
      ref_wr_addr = 12'd2;
      ref_wr_data = 16'd5;
      clk_step();
      asserts++;
      if (data_out_valid !== ev || ciclo_completo !== el ||
          data_out_i !== ei || data_out_q !== eq) begin
        fails++;
        $display("FAIL live k=%0d: v=%b c=%b i=%0d q=%0d, required %b %b %0d %0d",
                 k, data_out_valid, ciclo_completo, $signed(data_out_i),
                 $signed(data_out_q), ev, el, $signed(ei), $signed(eq));
      end
      if (data_out_valid === 1'b1 && n < 16) begin
        outs[n] = data_out_i;
        n++;
      end
    end
    ref_wr_en = 1'b0;
    asserts++;
    if (n != 12 || outs[2] !== 64'd3 || outs[10] !== 64'd5) begin
      fails++;
      $display("FAIL live_values: n=%0d out2=%0d out10=%0d, required 12 3 5",
               n, outs[2], outs[10]);
    end
  endtask

  task automatic test_back_to_back();
    int m;
    for (int r = 0; r < 3; r++) begin
      m = 4 * int'($urandom_range(1, 6));
      for (int k = 0; k < m; k++)
        write_tbl(k, int'($urandom_range(0, 65535)) - 32768);
      configure(m);
      enable = 1'b1;
      for (int k = 0; k < 40; k++) begin
        data_valid = (k < 36) && ($urandom_range(0, 3) != 0);
        data = 14'($urandom);
        ref_wr_en = ($urandom_range(0, 7) == 0);
        ref_wr_addr = 12'($urandom_range(0, m - 1));
        ref_wr_data = 16'($urandom);
        clk_step();
        asserts++;
        if (data_out_valid !== ev || ciclo_completo !== el ||
            data_out_i !== ei || data_out_q !== eq) begin
          fails++;
          $display("FAIL b2b r=%0d k=%0d: v=%b c=%b i=%0d q=%0d, required %b %b %0d %0d",
                   r, k, data_out_valid, ciclo_completo, $signed(data_out_i),
                   $signed(data_out_q), ev, el, $signed(ei), $signed(eq));
        end
      end
      ref_wr_en = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign(-32768, 64'sd268435456);
    test_sign(32767, -64'sd268427264);
    test_gapped();
    test_illegal();
    test_reset_mid();
    test_live_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule

// File: doc/multiplicador_referencia.md
# multiplicador_referencia

Lock-in mixing stage directly upstream of `filtro_promedio_movil`. It multiplies each ADC sample by a reference waveform stored in an on-chip table, indexed by the sample's position within the signal cycle. It emits 64-bit signed products as an Avalon-ST style stream, which the moving-average filter integrates over `ptos_x_ciclo * frames_integracion` samples. An optional quadrature (cosine) channel is produced from the same table.

## Interface
- `DATA_W`, 14: signed ADC sample width.
- `REF_W`, 16: signed reference sample width.
- `buf_tam`, 4096: reference table depth; the address is `$clog2(buf_tam)` bits.
- `clock`  in  1  sole clock; everything is synchronous to its rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `enable`  in  1  run enable; when low, the phase index is held at 0 and no samples are accepted.
- `ptos_x_ciclo`  in  16  M, the number of points per signal cycle; sampled only while `enable` is low.
- `ref_wr_en`  in  1  reference table write strobe.
- `ref_wr_addr`  in  $clog2(buf_tam)  reference table write address.
- `ref_wr_data`  in  REF_W  signed reference value.
- `data_valid`  in  1  input sample valid.
- `data`  in  DATA_W  signed ADC sample.
- `data_out_i`  out  64  signed in-phase product, sign-extended.
- `data_out_q`  out  64  signed quadrature product, sign-extended.
- `data_out_valid`  out  1  output valid.
- `ciclo_completo`  out  1  asserted with the output whose phase index was M-1.
- `error_config`  out  1  M is illegal.

## Operation
- **Configuration latch.** While `enable` is low, the block registers:
  - `M_reg` ← `ptos_x_ciclo`;
  - `cuarto` ← `ptos_x_ciclo >> 2`.
- **error_config** is registered. It is 1 when any of these hold:
  - `M_reg == 0`;
  - `M_reg > buf_tam`;
  - with `QUADRATURE_EN`, `M_reg[1:0] != 0`.
- **Sample acceptance.** A sample is accepted when `enable && data_valid && !error_config`. No other input is back-pressured; there is no ready output.
- **Phase index (`indice`).**
  - Reset value 0. Forced to 0 while `enable` is low.
  - Increments on each accepted sample.
  - Wraps from M-1 to 0.
- **Quadrature index.**
  - `indice_q = indice + cuarto`; if the result is ≥ M, subtract M.
  - Computed with a compare-and-subtract, never a divider.
- **Reference table.**
  - Single simple-dual-port RAM of depth `buf_tam`, one write port and two read ports (the second is used only with `QUADRATURE_EN`).
  - Writes are accepted in any state, including while running.
  - Read-during-write to the same address returns the old data.
  - Contents are not cleared by reset and are undefined until written.
- **Pipeline**, advancing on every clock edge with valid bits propagated:
  - Stage 1: register `data`, `indice`, `indice_q`, the accepted flag, and last-of-cycle (`indice == M-1`).
  - Stage 2: RAM read; the sample is delayed alongside.
  - Stage 3: signed multiply, DATA_W × REF_W → DATA_W+REF_W bits, sign-extended to 64. This drives `data_out_i`, `data_out_q`, `data_out_valid` and `ciclo_completo`.
- **Hold behaviour.** When a stage carries no valid sample, the output data registers hold their last value; only the valid and `ciclo_completo` signals drop.
- **Enable deasserted mid-stream.** Samples already in flight still emerge. On the next run, indexing restarts at 0.

## Timing
- **Latency.** A sample accepted at edge t appears at edge t+3 with `data_out_valid` = 1.
- **Throughput.** One sample per clock; back-to-back valids produce back-to-back outputs.
- **Reset values.**
  - `data_out_i`, `data_out_q`, `data_out_valid`, `ciclo_completo`: 0.
  - `error_config`: 1, because `M_reg` resets to 0.
  - `indice`, `M_reg`, `cuarto` and all pipeline valid bits: 0.
- **Reset mid-operation.** At the reset edge, all in-flight valids are cleared. No output is produced for samples accepted within the preceding 3 cycles.
- **ciclo_completo** is a single-cycle pulse coincident with `data_out_valid`. For M = 1 it is high on every output.
- **Table write latency.** A table write at edge t is visible to a read issued at stage 2 on edge t+1 or later.

## Configuration
- `MULTIPLICADOR_QUADRATURE_EN`:
  - **Defined:** second read port, quadrature index and second multiplier are instantiated; `data_out_q` = `data` × table[`indice_q`], a 90° shifted reference; the M%4 check is active in `error_config`.
  - **Undefined:** none of that logic is built; `data_out_q` is constant 0; the M%4 condition is removed from `error_config`.

## Test plan
- **Basic I/Q mixing.** Load table[k] = k+1 for k = 0..7, M = 8, enable = 1, and stream data = 100 for 16 cycles.
  - `data_out_i` = 100, 200, …, 800, repeated twice, first at cycle 3.
  - `ciclo_completo` high on the 8th and 16th outputs.
  - With quadrature, `data_out_q` = 300, 400, …, 800, 100, 200.
- **Sign extension.** data = -8192, table[0] = -32768, M = 1.
  - `data_out_i` = 268435456, upper bits zero.
  - data = -8192 with table[0] = 32767 gives -268427264, upper 34 bits ones.
- **Gapped input.** Toggle `data_valid` 1,0,1,0, M = 4.
  - `indice` advances only on valid samples.
  - `data_out_valid` mirrors the input pattern delayed 3 cycles.
- **Illegal configuration.**
  - M = 0: `error_config` = 1 and no outputs.
  - M = 4097: `error_config` = 1.
  - M = 6 with quadrature: `error_config` = 1.
  - M = 6 without quadrature: `error_config` = 0.
- **Reset mid-stream.** Pulse `reset_n` low for 1 cycle, 2 cycles after a burst of valids starts.
  - No further `data_out_valid` after the reset.
  - Outputs are 0 and `indice` restarts at 0.
- **Live table write.** Write table[2] = 5 in the same cycle a sample reads index 2.
  - That output uses the old value.
  - The next cycle's read of index 2 uses 5.
